// File: rtl/elementwise_ctrl.sv
// elementwise_ctrl: register-programmed sequencer issuing A/B reads and result writes per pixel.
// Optional busy-cycle counter at 0x0D when ELEMENTWISE_PERF_CNT_EN is defined.
module elementwise_ctrl #(
  parameter int unsigned PIX_BYTES = 64,
  parameter int unsigned DIM_W     = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        reg_wr_en,
  input  logic        reg_rd_en,
  input  logic [7:0]  reg_addr,
  input  logic [31:0] reg_wdata,
  output logic [31:0] reg_rdata,
  output logic        rd_req_vld,
  input  logic        rd_req_rdy,
  output logic [31:0] rd_req_addr,
  output logic        rd_req_sel,
  output logic        wr_req_vld,
  input  logic        wr_req_rdy,
  output logic [31:0] wr_req_addr,
  output logic [1:0]  ew_mode,
  output logic        done_irq
);

  localparam logic [31:0]      PIX_STEP = 32'(PIX_BYTES);
  localparam logic [DIM_W-1:0] ONE      = DIM_W'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD_A,
    S_RD_B,
    S_WR,
    S_DONE
  } state_t;

  state_t state_q, state_d;

  logic [DIM_W-1:0] h_q, h_d, w_q, w_d, ch_q, ch_d;
  logic [1:0]       mode_q, mode_d;
  logic [31:0]      a_base_q, a_base_d, b_base_q, b_base_d;
  logic [31:0]      in_surf_q, in_surf_d, in_line_q, in_line_d;
  logic [31:0]      out_base_q, out_base_d;
  logic [31:0]      out_surf_q, out_surf_d, out_line_q, out_line_d;
  logic             done_q, done_d;

  logic [DIM_W-1:0] wc_q, wc_d, hc_q, hc_d, cc_q, cc_d;
  logic [31:0]      w_off_q, w_off_d;
  logic [31:0]      in_h_off_q, in_h_off_d, in_c_off_q, in_c_off_d;
  logic [31:0]      out_h_off_q, out_h_off_d, out_c_off_q, out_c_off_d;

  logic [1:0]       ew_mode_q, ew_mode_d;
  logic             done_irq_q, done_irq_d;
  logic [31:0]      rdata_q, rdata_d;
  logic [31:0]      perf_rd;

  logic busy, cfg_we, start, zero_dim;
  logic rd_hs, wr_hs;
  logic last_w, last_h, last_c;
  logic step_w, step_h, step_c, step_fin;

  assign busy     = state_q != S_IDLE;
  assign cfg_we   = reg_wr_en && !busy;
  assign start    = cfg_we && reg_addr == 8'h00 && reg_wdata[0];
  assign zero_dim = (h_q == '0) || (w_q == '0) || (ch_q == '0);

  assign rd_hs = rd_req_vld && rd_req_rdy;
  assign wr_hs = wr_req_vld && wr_req_rdy;

  assign last_w   = wc_q == w_q - ONE;
  assign last_h   = hc_q == h_q - ONE;
  assign last_c   = cc_q == ch_q - ONE;
  assign step_w   = !last_w;
  assign step_h   = last_w && !last_h;
  assign step_c   = last_w && last_h && !last_c;
  assign step_fin = last_w && last_h && last_c;

  always_comb begin
    h_d        = h_q;
    w_d        = w_q;
    ch_d       = ch_q;
    mode_d     = mode_q;
    a_base_d   = a_base_q;
    b_base_d   = b_base_q;
    in_surf_d  = in_surf_q;
    in_line_d  = in_line_q;
    out_base_d = out_base_q;
    out_surf_d = out_surf_q;
    out_line_d = out_line_q;
    if (cfg_we) begin
      case (reg_addr)
        8'h02:   h_d        = reg_wdata[DIM_W-1:0];
        8'h03:   w_d        = reg_wdata[DIM_W-1:0];
        8'h04:   ch_d       = reg_wdata[DIM_W-1:0];
        8'h05:   mode_d     = reg_wdata[1:0];
        8'h06:   a_base_d   = reg_wdata;
        8'h07:   b_base_d   = reg_wdata;
        8'h08:   in_surf_d  = reg_wdata;
        8'h09:   in_line_d  = reg_wdata;
        8'h0A:   out_base_d = reg_wdata;
        8'h0B:   out_surf_d = reg_wdata;
        8'h0C:   out_line_d = reg_wdata;
        default: ;
      endcase
    end
  end

  // A DONE cycle sets the sticky flag even against a same-cycle clear.
  always_comb begin
    done_d = done_q;
    if (state_q == S_DONE) begin
      done_d = 1'b1;
    end else if (reg_wr_en && reg_addr == 8'h01 && reg_wdata[1]) begin
      done_d = 1'b0;
    end
  end

  always_comb begin
    state_d     = state_q;
    wc_d        = wc_q;
    hc_d        = hc_q;
    cc_d        = cc_q;
    w_off_d     = w_off_q;
    in_h_off_d  = in_h_off_q;
    in_c_off_d  = in_c_off_q;
    out_h_off_d = out_h_off_q;
    out_c_off_d = out_c_off_q;
    ew_mode_d   = ew_mode_q;
    done_irq_d  = state_q == S_DONE;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          ew_mode_d   = mode_q;
          wc_d        = '0;
          hc_d        = '0;
          cc_d        = '0;
          w_off_d     = '0;
          in_h_off_d  = '0;
          in_c_off_d  = '0;
          out_h_off_d = '0;
          out_c_off_d = '0;
          state_d     = zero_dim ? S_DONE : S_RD_A;
        end
      end
      S_RD_A: if (rd_hs) state_d = S_RD_B;
      S_RD_B: if (rd_hs) state_d = S_WR;
      S_WR: begin
        if (wr_hs) begin
          state_d = S_RD_A;
          unique case (1'b1)
            step_w: begin
              wc_d    = wc_q + ONE;
              w_off_d = w_off_q + PIX_STEP;
            end
            step_h: begin
              wc_d        = '0;
              w_off_d     = '0;
              hc_d        = hc_q + ONE;
              in_h_off_d  = in_h_off_q + in_line_q;
              out_h_off_d = out_h_off_q + out_line_q;
            end
            step_c: begin
              wc_d        = '0;
              w_off_d     = '0;
              hc_d        = '0;
              in_h_off_d  = '0;
              out_h_off_d = '0;
              cc_d        = cc_q + ONE;
              in_c_off_d  = in_c_off_q + in_surf_q;
              out_c_off_d = out_c_off_q + out_surf_q;
            end
            step_fin: begin
              wc_d        = '0;
              w_off_d     = '0;
              hc_d        = '0;
              in_h_off_d  = '0;
              out_h_off_d = '0;
              cc_d        = '0;
              in_c_off_d  = '0;
              out_c_off_d = '0;
              state_d     = S_DONE;
            end
          endcase
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    rdata_d = '0;
    if (reg_rd_en) begin
      case (reg_addr)
        8'h01:   rdata_d = {30'd0, done_q, busy};
        8'h02:   rdata_d = 32'(h_q);
        8'h03:   rdata_d = 32'(w_q);
        8'h04:   rdata_d = 32'(ch_q);
        8'h05:   rdata_d = {30'd0, mode_q};
        8'h06:   rdata_d = a_base_q;
        8'h07:   rdata_d = b_base_q;
        8'h08:   rdata_d = in_surf_q;
        8'h09:   rdata_d = in_line_q;
        8'h0A:   rdata_d = out_base_q;
        8'h0B:   rdata_d = out_surf_q;
        8'h0C:   rdata_d = out_line_q;
        8'h0D:   rdata_d = perf_rd;
        default: rdata_d = '0;
      endcase
    end
  end

`ifdef ELEMENTWISE_PERF_CNT_EN
  logic [31:0] perf_q, perf_d;

  // The launch cycle counts as the first busy cycle.
  always_comb begin
    perf_d = perf_q;
    if (start) begin
      perf_d = 32'd1;
    end else if (busy && perf_q != '1) begin
      perf_d = perf_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) perf_q <= '0;
    else        perf_q <= perf_d;
  end

  assign perf_rd = perf_q;
`else
  assign perf_rd = '0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      h_q         <= '0;
      w_q         <= '0;
      ch_q        <= '0;
      mode_q      <= '0;
      a_base_q    <= '0;
      b_base_q    <= '0;
      in_surf_q   <= '0;
      in_line_q   <= '0;
      out_base_q  <= '0;
      out_surf_q  <= '0;
      out_line_q  <= '0;
      done_q      <= 1'b0;
      wc_q        <= '0;
      hc_q        <= '0;
      cc_q        <= '0;
      w_off_q     <= '0;
      in_h_off_q  <= '0;
      in_c_off_q  <= '0;
      out_h_off_q <= '0;
      out_c_off_q <= '0;
      ew_mode_q   <= '0;
      done_irq_q  <= 1'b0;
      rdata_q     <= '0;
    end else begin
      state_q     <= state_d;
      h_q         <= h_d;
      w_q         <= w_d;
      ch_q        <= ch_d;
      mode_q      <= mode_d;
      a_base_q    <= a_base_d;
      b_base_q    <= b_base_d;
      in_surf_q   <= in_surf_d;
      in_line_q   <= in_line_d;
      out_base_q  <= out_base_d;
      out_surf_q  <= out_surf_d;
      out_line_q  <= out_line_d;
      done_q      <= done_d;
      wc_q        <= wc_d;
      hc_q        <= hc_d;
      cc_q        <= cc_d;
      w_off_q     <= w_off_d;
      in_h_off_q  <= in_h_off_d;
      in_c_off_q  <= in_c_off_d;
      out_h_off_q <= out_h_off_d;
      out_c_off_q <= out_c_off_d;
      ew_mode_q   <= ew_mode_d;
      done_irq_q  <= done_irq_d;
      rdata_q     <= rdata_d;
    end
  end

  assign rd_req_vld  = (state_q == S_RD_A) || (state_q == S_RD_B);
  assign rd_req_sel  = state_q == S_RD_B;
  assign rd_req_addr = rd_req_vld
                     ? (rd_req_sel ? b_base_q : a_base_q)
                       + in_c_off_q + in_h_off_q + w_off_q
                     : '0;
  assign wr_req_vld  = state_q == S_WR;
  assign wr_req_addr = wr_req_vld
                     ? out_base_q + out_c_off_q + out_h_off_q + w_off_q
                     : '0;
  assign ew_mode     = ew_mode_q;
  assign done_irq    = done_irq_q;
  assign reg_rdata   = rdata_q;

endmodule

// File: tb/tb_elementwise_ctrl.sv
// tb_elementwise_ctrl: directed and randomized jobs against a loop-nest address model.
// Handshakes are logged by monitors; the initial block compares them to the model.
module tb_elementwise_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        reg_wr_en, reg_rd_en;
  logic [7:0]  reg_addr;
  logic [31:0] reg_wdata, reg_rdata;
  logic        rd_req_vld, rd_req_rdy, rd_req_sel;
  logic        wr_req_vld, wr_req_rdy, done_irq;
  logic [31:0] rd_req_addr, wr_req_addr;
  logic [1:0]  ew_mode;

  always #5 clk = ~clk;

  elementwise_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .reg_wr_en(reg_wr_en), .reg_rd_en(reg_rd_en),
    .reg_addr(reg_addr), .reg_wdata(reg_wdata), .reg_rdata(reg_rdata),
    .rd_req_vld(rd_req_vld), .rd_req_rdy(rd_req_rdy),
    .rd_req_addr(rd_req_addr), .rd_req_sel(rd_req_sel),
    .wr_req_vld(wr_req_vld), .wr_req_rdy(wr_req_rdy),
    .wr_req_addr(wr_req_addr), .ew_mode(ew_mode), .done_irq(done_irq)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int irq_cnt = 0, irq_cyc = 0;
  int stall_b = 0, stall_used = 0, stall_req = 0, stab_viol = 0;
  int last_wr_cyc = 0, st_cyc = 0, irq0 = 0, rb = 0, wb = 0;
  bit rnd_rdy = 1'b0;

  logic [32:0] rdq[$];
  logic [32:0] exp_rd[$];
  logic [31:0] wrq[$];
  logic [31:0] exp_wr[$];
  logic        pend_rd = 1'b0, pend_wr = 1'b0;
  logic [32:0] pend_rd_v;
  logic [31:0] pend_wr_v;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rd_req_vld && rd_req_rdy) rdq.push_back({rd_req_sel, rd_req_addr});
    if (wr_req_vld && wr_req_rdy) wrq.push_back(wr_req_addr);
    if (rd_req_vld && !rd_req_rdy && rd_req_sel) stall_b <= stall_b + 1;
    pend_rd   <= rst_n && rd_req_vld && !rd_req_rdy;
    pend_rd_v <= {rd_req_sel, rd_req_addr};
    pend_wr   <= rst_n && wr_req_vld && !wr_req_rdy;
    pend_wr_v <= wr_req_addr;
  end

  always @(negedge clk) begin
    if (rst_n && pend_rd && !(rd_req_vld && {rd_req_sel, rd_req_addr} == pend_rd_v))
      stab_viol <= stab_viol + 1;
    if (rst_n && pend_wr && !(wr_req_vld && wr_req_addr == pend_wr_v))
      stab_viol <= stab_viol + 1;
    if (done_irq) begin
      irq_cnt <= irq_cnt + 1;
      irq_cyc <= cyc;
    end
  end

  always @(negedge clk) begin
    rd_req_rdy <= rnd_rdy ? ($urandom_range(0, 3) != 0) : 1'b1;
    wr_req_rdy <= rnd_rdy ? ($urandom_range(0, 3) != 0) : 1'b1;
    if (stall_used < stall_req && rd_req_vld && rd_req_sel) begin
      rd_req_rdy <= 1'b0;
      stall_used <= stall_used + 1;
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wr_reg(input logic [7:0] a, input logic [31:0] d);
    @(negedge clk);
    reg_wr_en = 1'b1;
    reg_addr  = a;
    reg_wdata = d;
    @(negedge clk);
    reg_wr_en   = 1'b0;
    last_wr_cyc = cyc;
  endtask

  task automatic rd_reg(input logic [7:0] a, output logic [31:0] d);
    @(negedge clk);
    reg_rd_en = 1'b1;
    reg_addr  = a;
    @(negedge clk);
    reg_rd_en = 1'b0;
    d = reg_rdata;
  endtask

  task automatic model(input int h, input int w, input int ch,
                       input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] isf, input logic [31:0] iln,
                       input logic [31:0] ob, input logic [31:0] osf,
                       input logic [31:0] oln);
    exp_rd.delete();
    exp_wr.delete();
    for (int c = 0; c < ch; c++)
      for (int y = 0; y < h; y++)
        for (int x = 0; x < w; x++) begin
          logic [31:0] ioff, ooff;
          ioff = 32'(c) * isf + 32'(y) * iln + 32'(x) * 32'd64;
          ooff = 32'(c) * osf + 32'(y) * oln + 32'(x) * 32'd64;
          exp_rd.push_back({1'b0, a + ioff});
          exp_rd.push_back({1'b1, b + ioff});
          exp_wr.push_back(ob + ooff);
        end
  endtask

  task automatic setup(input int h, input int w, input int ch, input logic [1:0] m,
                       input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] isf, input logic [31:0] iln,
                       input logic [31:0] ob, input logic [31:0] osf,
                       input logic [31:0] oln);
    wr_reg(8'h02, 32'(h));
    wr_reg(8'h03, 32'(w));
    wr_reg(8'h04, 32'(ch));
    wr_reg(8'h05, {30'd0, m});
    wr_reg(8'h06, a);
    wr_reg(8'h07, b);
    wr_reg(8'h08, isf);
    wr_reg(8'h09, iln);
    wr_reg(8'h0A, ob);
    wr_reg(8'h0B, osf);
    wr_reg(8'h0C, oln);
    model(h, w, ch, a, b, isf, iln, ob, osf, oln);
  endtask

  task automatic start_job();
    rb   = rdq.size();
    wb   = wrq.size();
    irq0 = irq_cnt;
    wr_reg(8'h00, 32'd1);
    st_cyc = last_wr_cyc;
  endtask

  task automatic wait_irq(input string tag, input int bound);
    int n = 0;
    while (irq_cnt == irq0 && n < bound) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    chk({tag, "_irq_seen"}, 64'(irq_cnt != irq0), 64'd1);
  endtask

  task automatic cmp_job(input string tag);
    chk({tag, "_rd_cnt"}, 64'(rdq.size() - rb), 64'(exp_rd.size()));
    chk({tag, "_wr_cnt"}, 64'(wrq.size() - wb), 64'(exp_wr.size()));
    foreach (exp_rd[i])
      if (rb + i < rdq.size())
        chk($sformatf("%s_rd%0d", tag, i), 64'(rdq[rb + i]), 64'(exp_rd[i]));
    foreach (exp_wr[i])
      if (wb + i < wrq.size())
        chk($sformatf("%s_wr%0d", tag, i), 64'(wrq[wb + i]), 64'(exp_wr[i]));
  endtask

  initial begin
    logic [31:0] d;
    int n;
    int h, w, ch;
    logic [1:0] m;
    logic [31:0] a, b, isf, iln, ob, osf, oln;

    rst_n     = 1'b0;
    reg_wr_en = 1'b0;
    reg_rd_en = 1'b0;
    reg_addr  = '0;
    reg_wdata = '0;
    repeat (3) @(negedge clk);
    chk("rst_rd_vld", 64'(rd_req_vld), 64'd0);
    chk("rst_wr_vld", 64'(wr_req_vld), 64'd0);
    chk("rst_irq", 64'(done_irq), 64'd0);
    chk("rst_mode", 64'(ew_mode), 64'd0);
    chk("rst_rdata", 64'(reg_rdata), 64'd0);
    rst_n = 1'b1;
    rd_reg(8'h01, d);
    chk("rst_status", 64'(d), 64'd0);
    rd_reg(8'h02, d);
    chk("rst_h", 64'(d), 64'd0);

    // Reference job: 2 channels x 17 pixels, ready always high.
    setup(1, 17, 2, 2'd2, 32'h0, 32'h0100_0000, 32'd1088, 32'd1088,
          32'h0800_0000, 32'd1088, 32'd1088);
    rd_reg(8'h03, d);
    chk("rb_w", 64'(d), 64'd17);
    rd_reg(8'h0C, d);
    chk("rb_out_line", 64'(d), 64'd1088);
    rd_reg(8'h05, d);
    chk("rb_mode", 64'(d), 64'd2);
    rd_reg(8'h20, d);
    chk("rb_unmapped", 64'(d), 64'd0);
    start_job();
    chk("j1_mode", 64'(ew_mode), 64'd2);
    rd_reg(8'h01, d);
    chk("j1_busy", 64'(d), 64'd1);
    wait_irq("j1", 500);
    chk("j1_irq_lat", 64'(irq_cyc - st_cyc), 64'd103);
    chk("j1_irq_once", 64'(irq_cnt - irq0), 64'd1);
    chk("j1_rd_cnt34", 64'(rdq.size() - rb), 64'd68);
    chk("j1_a2", 64'(rdq[rb + 2]), 64'({1'b0, 32'h40}));
    chk("j1_c1_a", 64'(rdq[rb + 34]), 64'({1'b0, 32'h440}));
    chk("j1_last_wr", 64'(wrq[wrq.size() - 1]), 64'h0800_0840);
    cmp_job("j1");
    chk("j1_mode_held", 64'(ew_mode), 64'd2);
    rd_reg(8'h0D, d);
`ifdef ELEMENTWISE_PERF_CNT_EN
    chk("j1_perf", 64'(d), 64'd104);
`else
    chk("j1_perf", 64'(d), 64'd0);
`endif
    rd_reg(8'h01, d);
    chk("j1_status", 64'(d), 64'd2);
    wr_reg(8'h01, 32'd2);

    // Same job with B read held off for five cycles.
    stall_req = stall_used + 5;
    n = stall_b;
    start_job();
    wait_irq("j2", 500);
    chk("j2_stalls", 64'(stall_b - n), 64'd5);
    chk("j2_stable", 64'(stab_viol), 64'd0);
    chk("j2_irq_lat", 64'(irq_cyc - st_cyc), 64'd108);
    cmp_job("j2");
    wr_reg(8'h01, 32'd2);

    // Zero width: straight to DONE.
    wr_reg(8'h03, 32'd0);
    model(1, 0, 2, 0, 0, 0, 0, 0, 0, 0);
    start_job();
    wait_irq("j3", 50);
    chk("j3_irq_lat", 64'(irq_cyc - st_cyc), 64'd1);
    cmp_job("j3");
    rd_reg(8'h01, d);
    chk("j3_status", 64'(d), 64'd2);
    wr_reg(8'h01, 32'd2);
    rd_reg(8'h01, d);
    chk("j3_status_clr", 64'(d), 64'd0);

    // Clear write landing in the DONE cycle loses to the set.
    irq0 = irq_cnt;
    @(negedge clk);
    reg_wr_en = 1'b1;
    reg_addr  = 8'h00;
    reg_wdata = 32'd1;
    @(negedge clk);
    reg_addr  = 8'h01;
    reg_wdata = 32'd2;
    @(negedge clk);
    reg_wr_en = 1'b0;
    rd_reg(8'h01, d);
    chk("set_wins", 64'(d), 64'd2);
    wr_reg(8'h01, 32'd2);

    // Config writes and restart while busy are ignored.
    setup(1, 17, 2, 2'd1, 32'h0, 32'h0100_0000, 32'd1088, 32'd1088,
          32'h0800_0000, 32'd1088, 32'd1088);
    start_job();
    wr_reg(8'h02, 32'd5);
    rd_reg(8'h02, d);
    chk("busy_h_write", 64'(d), 64'd1);
    wr_reg(8'h05, 32'd0);
    wr_reg(8'h00, 32'd1);
    chk("busy_mode", 64'(ew_mode), 64'd1);
    wait_irq("j4", 500);
    repeat (20) @(negedge clk);
    chk("j4_irq_once", 64'(irq_cnt - irq0), 64'd1);
    cmp_job("j4");
    rd_reg(8'h05, d);
    chk("busy_mode_rb", 64'(d), 64'd1);

    // Randomized jobs with random back-pressure.
    rnd_rdy = 1'b1;
    for (int j = 0; j < 4; j++) begin
      h   = $urandom_range(1, 3);
      w   = $urandom_range(1, 6);
      ch  = $urandom_range(1, 3);
      m   = 2'($urandom_range(0, 2));
      a   = $urandom;
      b   = $urandom;
      isf = $urandom;
      iln = $urandom;
      ob  = $urandom;
      osf = $urandom;
      oln = $urandom;
      setup(h, w, ch, m, a, b, isf, iln, ob, osf, oln);
      start_job();
      chk($sformatf("r%0d_mode", j), 64'(ew_mode), 64'(m));
      wait_irq($sformatf("r%0d", j), 3000);
      cmp_job($sformatf("r%0d", j));
      rd_reg(8'h09, d);
      chk($sformatf("r%0d_rb_line", j), 64'(d), 64'(iln));
    end
    rnd_rdy = 1'b0;
    chk("rnd_stable", 64'(stab_viol), 64'd0);

    // Reset in the middle of a job.
    setup(1, 17, 2, 2'd1, 32'h0, 32'h0100_0000, 32'd1088, 32'd1088,
          32'h0800_0000, 32'd1088, 32'd1088);
    start_job();
    n = 0;
    while (wrq.size() - wb < 10 && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk("rst_job_10wr", 64'(wrq.size() - wb), 64'd10);
    chk("rst_job_active", 64'(rd_req_vld | wr_req_vld), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_rd_vld", 64'(rd_req_vld), 64'd0);
    chk("mid_rst_wr_vld", 64'(wr_req_vld), 64'd0);
    chk("mid_rst_rd_addr", 64'(rd_req_addr), 64'd0);
    chk("mid_rst_wr_addr", 64'(wr_req_addr), 64'd0);
    chk("mid_rst_sel", 64'(rd_req_sel), 64'd0);
    chk("mid_rst_mode", 64'(ew_mode), 64'd0);
    chk("mid_rst_irq", 64'(done_irq), 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    rb = rdq.size();
    wb = wrq.size();
    repeat (30) @(negedge clk);
    chk("post_rst_rd", 64'(rdq.size() - rb), 64'd0);
    chk("post_rst_wr", 64'(wrq.size() - wb), 64'd0);
    rd_reg(8'h01, d);
    chk("post_rst_status", 64'(d), 64'd0);
    rd_reg(8'h03, d);
    chk("post_rst_w", 64'(d), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
